// File: rtl/led_color_sequencer_pkg.sv
// Shared definitions for the LED colour sequencer: register map, CTRL/STATUS
// bit positions, and the sequencer state encoding.
package led_color_sequencer_pkg;

    localparam logic [3:0] ADDR_CTRL       = 4'd0;
    localparam logic [3:0] ADDR_DWELL      = 4'd1;
    localparam logic [3:0] ADDR_FADE_DIV   = 4'd2;
    localparam logic [3:0] ADDR_LEN        = 4'd3;
    localparam logic [3:0] ADDR_STATUS     = 4'd4;
    localparam logic [3:0] ADDR_MANUAL     = 4'd5;
    localparam logic [3:0] ADDR_TABLE_BASE = 4'd8;

    localparam int CTRL_RUN  = 0;
    localparam int CTRL_LOOP = 1;
    localparam int CTRL_FADE = 2;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_IDX_LSB = 4;
    localparam int STAT_DONE    = 8;

    // Table index width is fixed by the 8-entry window at addresses 8..15.
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FADE,
        ST_HOLD
    } state_t;

    // LEN of 0 plays one entry; anything beyond the table depth is clamped.
    function automatic logic [3:0] eff_len(input logic [3:0] len, input logic [3:0] depth);
        if (len == 4'd0)
            return 4'd1;
        else if (len > depth)
            return depth;
        else
            return len;
    endfunction

endpackage

// File: rtl/led_seq_timer.sv
// Loadable down-counter; o_expire is the terminal-count compare (count == 0).
// Loading N-1 therefore yields an expiry N cycles after the load edge.
module led_seq_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_expire
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_count <= '0;
        else if (i_load)
            r_count <= i_load_val;
        else if (r_count != '0)
            r_count <= r_count - W'(1);
    end

    assign o_expire = (r_count == '0);

endmodule

// File: rtl/led_color_sequencer.sv
// Avalon-MM LED colour sequencer: steps an 8-bit level through a table with
// per-entry dwell, optional linear fade, and one-shot or looping playback.
//
//   state | meaning
//   IDLE  | level follows MANUAL; waits for a CTRL write with run=1
//   FADE  | level steps +/-1 toward TABLE[idx] every FADE_DIV cycles
//   HOLD  | level holds TABLE[idx] for DWELL cycles, then advances or ends
module led_color_sequencer
    import led_color_sequencer_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int DWELL_W = 24,
    parameter int FDIV_W  = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  out_port,
    output logic        irq
);

    state_t             r_state;
    logic [2:0]         r_ctrl;
    logic [DWELL_W-1:0] r_dwell;
    logic [FDIV_W-1:0]  r_fdiv;
    logic [3:0]         r_len;
    logic [7:0]         r_manual;
    logic [7:0]         r_table [DEPTH];
    logic               r_done;
    logic [IDX_W-1:0]   r_idx;
    logic [7:0]         r_level;

    logic               w_wr;
    logic               w_ctrl_wr;
    logic               w_start;
    logic               w_start_fade;
    logic               w_abort;
    logic [3:0]         w_tbl_off;
    logic               w_tbl_hit;
    logic [3:0]         w_len_eff;
    logic               w_last;
    logic               w_continue;
    logic [IDX_W-1:0]   w_next_idx;
    logic [7:0]         w_target;
    logic               w_at_target;
    logic               w_hold_exp;
    logic               w_fade_step;
    logic               w_dwell_exp;
    logic               w_div_exp;
    logic               w_dwell_load;
    logic               w_div_load;
    logic [DWELL_W-1:0] w_dwell_m1;
    logic [FDIV_W-1:0]  w_div_m1;
    logic [31:0]        w_status;
    logic               w_unused_wdata;

    assign w_wr         = chipselect & ~write_n;
    assign w_ctrl_wr    = w_wr & (address == ADDR_CTRL);
    assign w_start      = w_ctrl_wr & writedata[CTRL_RUN] & (r_state == ST_IDLE);
    assign w_start_fade = writedata[CTRL_FADE];
    assign w_abort      = w_ctrl_wr & ~writedata[CTRL_RUN] & (r_state != ST_IDLE);

    assign w_tbl_off = address - ADDR_TABLE_BASE;
    assign w_tbl_hit = address[3] & (w_tbl_off < 4'(DEPTH));

    // idx at or past the (possibly shrunk) length counts as the last entry.
    assign w_len_eff   = eff_len(r_len, 4'(DEPTH));
    assign w_last      = ({1'b0, r_idx} + 4'd1) >= w_len_eff;
    assign w_continue  = ~w_last | r_ctrl[CTRL_LOOP];
    assign w_next_idx  = w_last ? '0 : r_idx + IDX_W'(1);
    assign w_target    = r_table[r_idx];
    assign w_at_target = (r_level == w_target);

    assign w_hold_exp  = (r_state == ST_HOLD) & w_dwell_exp & ~w_abort;
    assign w_fade_step = (r_state == ST_FADE) & ~w_abort & ~w_at_target & w_div_exp;

    assign w_dwell_m1 = (r_dwell == '0) ? '0 : r_dwell - DWELL_W'(1);
    assign w_div_m1   = (r_fdiv == '0) ? '0 : r_fdiv - FDIV_W'(1);

    assign w_dwell_load = (w_start & ~w_start_fade)
                        | ((r_state == ST_FADE) & ~w_abort & w_at_target)
                        | (w_hold_exp & w_continue & ~r_ctrl[CTRL_FADE]);
    assign w_div_load   = (w_start & w_start_fade)
                        | w_fade_step
                        | (w_hold_exp & w_continue & r_ctrl[CTRL_FADE]);

    led_seq_timer #(.W(DWELL_W)) u_dwell_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_dwell_load),
        .i_load_val (w_dwell_m1),
        .o_expire   (w_dwell_exp)
    );

    led_seq_timer #(.W(FDIV_W)) u_fade_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_div_load),
        .i_load_val (w_div_m1),
        .o_expire   (w_div_exp)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dwell  <= '0;
            r_fdiv   <= '0;
            r_len    <= '0;
            r_manual <= '0;
            for (int i = 0; i < DEPTH; i++)
                r_table[i] <= '0;
        end else if (w_wr) begin
            case (address)
                ADDR_DWELL:    r_dwell  <= writedata[DWELL_W-1:0];
                ADDR_FADE_DIV: r_fdiv   <= writedata[FDIV_W-1:0];
                ADDR_LEN:      r_len    <= writedata[3:0];
                ADDR_MANUAL:   r_manual <= writedata[7:0];
                default: begin
                    if (w_tbl_hit)
                        r_table[w_tbl_off[IDX_W-1:0]] <= writedata[7:0];
                end
            endcase
        end
    end

    // CTRL and done live here because the sequencer also modifies them; the
    // done set is ordered after the W1C so a coincident end of sequence wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_ctrl  <= '0;
            r_done  <= 1'b0;
            r_idx   <= '0;
            r_level <= '0;
        end else begin
            if (w_ctrl_wr) begin
                if ((r_state != ST_IDLE) && writedata[CTRL_RUN]) begin
                    r_ctrl[CTRL_LOOP] <= writedata[CTRL_LOOP];
                    r_ctrl[CTRL_FADE] <= writedata[CTRL_FADE];
                end else begin
                    r_ctrl <= writedata[2:0];
                end
            end
            if (w_wr && (address == ADDR_STATUS) && writedata[STAT_DONE])
                r_done <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    r_level <= r_manual;
                    if (w_start) begin
                        r_idx <= '0;
                        if (w_start_fade) begin
                            r_state <= ST_FADE;
                        end else begin
                            r_level <= r_table[0];
                            r_state <= ST_HOLD;
                        end
                    end
                end
                ST_FADE: begin
                    if (w_abort)
                        r_state <= ST_IDLE;
                    else if (w_at_target)
                        r_state <= ST_HOLD;
                    else if (w_div_exp)
                        r_level <= (r_level < w_target) ? r_level + 8'd1 : r_level - 8'd1;
                end
                ST_HOLD: begin
                    if (w_abort) begin
                        r_state <= ST_IDLE;
                    end else if (w_dwell_exp) begin
                        if (!w_continue) begin
                            r_state          <= ST_IDLE;
                            r_level          <= r_manual;
                            r_ctrl[CTRL_RUN] <= 1'b0;
                            r_done           <= 1'b1;
                        end else begin
                            r_idx <= w_next_idx;
                            if (r_ctrl[CTRL_FADE])
                                r_state <= ST_FADE;
                            else
                                r_level <= r_table[w_next_idx];
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_status                              = '0;
        w_status[STAT_BUSY]                   = (r_state != ST_IDLE);
        w_status[STAT_IDX_LSB +: IDX_W]       = r_idx;
        w_status[STAT_DONE]                   = r_done;
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_CTRL:     readdata[2:0]         = r_ctrl;
            ADDR_DWELL:    readdata[DWELL_W-1:0] = r_dwell;
            ADDR_FADE_DIV: readdata[FDIV_W-1:0]  = r_fdiv;
            ADDR_LEN:      readdata[3:0]         = r_len;
            ADDR_STATUS:   readdata              = w_status;
            ADDR_MANUAL:   readdata[7:0]         = r_manual;
            default: begin
                if (w_tbl_hit)
                    readdata[7:0] = r_table[w_tbl_off[IDX_W-1:0]];
            end
        endcase
    end

    assign w_unused_wdata = &{1'b0, writedata[31:DWELL_W]};

    assign out_port = r_level;
    assign irq      = r_done;

endmodule

// File: tb/tb_led_color_sequencer.sv
// Self-checking bench for led_color_sequencer: randomized table playback
// compared cycle-by-cycle against a per-entry timeline model.
module tb_led_color_sequencer;

    localparam int DEPTH = 8;
    localparam logic [3:0] A_CTRL   = 4'd0;
    localparam logic [3:0] A_DWELL  = 4'd1;
    localparam logic [3:0] A_FDIV   = 4'd2;
    localparam logic [3:0] A_LEN    = 4'd3;
    localparam logic [3:0] A_STATUS = 4'd4;
    localparam logic [3:0] A_MANUAL = 4'd5;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [7:0]  out_port;
    logic        irq;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] m_tbl [DEPTH];
    int         m_len, m_dwell, m_fdiv, m_periods;
    bit         m_fade;
    logic [7:0] m_start;
    logic [7:0] exp_lvl [$];
    int         exp_idx [$];

    led_color_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    // Timeline per entry: with fade, the current level is shown FADE_DIV cycles
    // per unit of distance, then the target for one arrival cycle plus DWELL;
    // without fade, the target is shown for DWELL cycles.
    function automatic void build_model();
        int len_eff, dw, fd, lvl, t;
        exp_lvl.delete();
        exp_idx.delete();
        len_eff = (m_len == 0) ? 1 : (m_len > DEPTH) ? DEPTH : m_len;
        dw      = (m_dwell == 0) ? 1 : m_dwell;
        fd      = (m_fdiv == 0) ? 1 : m_fdiv;
        lvl     = int'(m_start);
        for (int p = 0; p < m_periods; p++) begin
            for (int e = 0; e < len_eff; e++) begin
                t = int'(m_tbl[e]);
                if (m_fade) begin
                    while (lvl != t) begin
                        for (int k = 0; k < fd; k++) begin
                            exp_lvl.push_back(8'(lvl));
                            exp_idx.push_back(e);
                        end
                        lvl += (t > lvl) ? 1 : -1;
                    end
                    exp_lvl.push_back(8'(lvl));
                    exp_idx.push_back(e);
                end
                lvl = t;
                for (int k = 0; k < dw; k++) begin
                    exp_lvl.push_back(8'(t));
                    exp_idx.push_back(e);
                end
            end
        end
    endfunction

    task automatic program_regs();
        bus_write(A_MANUAL, 32'(m_start));
        for (int i = 0; i < DEPTH; i++)
            bus_write(4'(8 + i), 32'(m_tbl[i]));
        bus_write(A_LEN, 32'(m_len));
        bus_write(A_DWELL, 32'(m_dwell));
        bus_write(A_FDIV, 32'(m_fdiv));
    endtask

    task automatic run_oneshot(input string name);
        logic [31:0] rd;
        bit          ok;
        int          bad;
        logic [7:0]  bad_act;
        program_regs();
        m_periods = 1;
        build_model();
        bus_write(A_CTRL, {29'd0, m_fade, 2'b01});
        ok  = 1'b1;
        bad = 0;
        bad_act = '0;
        for (int i = 0; i < exp_lvl.size(); i++) begin
            if (ok && (out_port !== exp_lvl[i])) begin
                ok = 1'b0; bad = i; bad_act = out_port;
            end
            @(negedge clk);
        end
        n_total++;
        if (!ok) $display("FAIL %s trace: cycle %0d out_port=%h expected %h", name, bad, bad_act, exp_lvl[bad]);
        else n_pass++;
        n_total++;
        if (out_port !== m_start) $display("FAIL %s end_level: out_port=%h expected %h", name, out_port, m_start);
        else n_pass++;
        bus_read(A_STATUS, rd);
        n_total++;
        if (rd[8] !== 1'b1 || irq !== 1'b1 || rd[0] !== 1'b0)
            $display("FAIL %s end_status: status=%h irq=%b expected done=1 busy=0 irq=1", name, rd, irq);
        else n_pass++;
        bus_read(A_CTRL, rd);
        n_total++;
        if (rd[0] !== 1'b0) $display("FAIL %s end_run: ctrl=%h expected run=0", name, rd);
        else n_pass++;
        bus_write(A_STATUS, 32'h100);
        n_total++;
        if (irq !== 1'b0) $display("FAIL %s w1c: irq=%b expected 0", name, irq);
        else n_pass++;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        for (int a = 0; a < 16; a++) begin
            bus_read(4'(a), rd);
            n_total++;
            if (rd !== 32'd0) $display("FAIL reset_read addr %0d: readdata=%h expected 0", a, rd);
            else n_pass++;
        end
        n_total++;
        if (out_port !== 8'h00 || irq !== 1'b0) $display("FAIL reset_out: out_port=%h irq=%b expected 00/0", out_port, irq);
        else n_pass++;
        bus_write(A_MANUAL, 32'h5A);
        @(negedge clk);
        n_total++;
        if (out_port !== 8'h5A) $display("FAIL manual: out_port=%h expected 5a", out_port);
        else n_pass++;
        bus_write(4'd6, 32'hFFFF_FFFF);
        bus_write(4'd7, 32'hFFFF_FFFF);
        for (int a = 6; a < 8; a++) begin
            bus_read(4'(a), rd);
            n_total++;
            if (rd !== 32'd0) $display("FAIL reserved addr %0d: readdata=%h expected 0", a, rd);
            else n_pass++;
        end
    endtask

    task automatic test_oneshot_nofade();
        m_tbl = '{8'h10, 8'h20, 8'h30, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        m_start = 8'h5A; m_len = 3; m_dwell = 4; m_fdiv = 1; m_fade = 1'b0;
        run_oneshot("oneshot_nofade");
    endtask

    task automatic test_fade();
        m_tbl = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        m_start = 8'h00; m_len = 1; m_dwell = 2; m_fdiv = 3; m_fade = 1'b1;
        run_oneshot("fade_up");
        m_tbl[0] = 8'h03;
        m_start  = 8'h08;
        run_oneshot("fade_down");
    endtask

    task automatic test_loop();
        logic [31:0] rd;
        bit          ok;
        int          bad;
        m_tbl = '{8'h11, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        m_start = 8'h66; m_len = 2; m_dwell = 3; m_fdiv = 1; m_fade = 1'b0;
        program_regs();
        m_periods = 3;
        build_model();
        bus_write(A_CTRL, 32'h3);
        ok = 1'b1;
        bad = 0;
        for (int i = 0; i < exp_lvl.size(); i++) begin
            bus_read(A_STATUS, rd);
            if (ok && (out_port !== exp_lvl[i] || int'(rd[6:4]) != exp_idx[i] || rd[8] !== 1'b0 || rd[0] !== 1'b1)) begin
                ok = 1'b0; bad = i;
                $display("FAIL loop trace: cycle %0d out_port=%h status=%h expected level %h idx %0d", i, out_port, rd, exp_lvl[i], exp_idx[i]);
            end
            @(negedge clk);
        end
        n_total++;
        if (ok) n_pass++;
        bus_write(A_CTRL, 32'h0);
        bus_read(A_STATUS, rd);
        n_total++;
        if (rd[0] !== 1'b0 || rd[8] !== 1'b0 || irq !== 1'b0)
            $display("FAIL abort_status: status=%h irq=%b expected busy=0 done=0", rd, irq);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (out_port !== 8'h66) $display("FAIL abort_level: out_port=%h expected 66", out_port);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < DEPTH; i++)
                m_tbl[i] = 8'($urandom_range(0, 40));
            m_start = 8'($urandom_range(0, 40));
            m_len   = $urandom_range(0, 15);
            m_dwell = $urandom_range(0, 5);
            m_fdiv  = $urandom_range(0, 3);
            m_fade  = 1'($urandom_range(0, 1));
            if (r == 0) begin m_len = 0;  m_dwell = 0; m_fdiv = 0; m_fade = 1'b1; end
            if (r == 1) begin m_len = 15; m_dwell = 0; m_fade = 1'b0; end
            if (r == 2) begin m_len = 15; m_fade = 1'b1; end
            run_oneshot($sformatf("random%0d", r));
        end
    endtask

    task automatic test_reset_mid_fade();
        logic [31:0] rd;
        m_tbl = '{8'h30, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        m_start = 8'h00; m_len = 1; m_dwell = 1; m_fdiv = 2; m_fade = 1'b1;
        program_regs();
        m_periods = 1;
        build_model();
        bus_write(A_CTRL, 32'h5);
        repeat (10) @(negedge clk);
        n_total++;
        if (out_port !== exp_lvl[10]) $display("FAIL midfade_level: out_port=%h expected %h", out_port, exp_lvl[10]);
        else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_total++;
        if (out_port !== 8'h00 || irq !== 1'b0) $display("FAIL async_reset_out: out_port=%h irq=%b expected 00/0", out_port, irq);
        else n_pass++;
        for (int a = 0; a < 16; a++) begin
            bus_read(4'(a), rd);
            n_total++;
            if (rd !== 32'd0) $display("FAIL async_reset_read addr %0d: readdata=%h expected 0", a, rd);
            else n_pass++;
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        bus_read(A_STATUS, rd);
        n_total++;
        if (out_port !== 8'h00 || rd !== 32'd0) $display("FAIL after_reset: out_port=%h status=%h expected 00/0", out_port, rd);
        else n_pass++;
    endtask

    task automatic test_done_collision();
        logic [31:0] rd;
        m_tbl = '{8'h44, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        m_start = 8'h77; m_len = 1; m_dwell = 2; m_fdiv = 1; m_fade = 1'b0;
        program_regs();
        bus_write(A_CTRL, 32'h1);
        // The W1C lands on the same edge as the single 2-cycle dwell expiry.
        bus_write(A_STATUS, 32'h100);
        bus_read(A_STATUS, rd);
        n_total++;
        if (rd[8] !== 1'b1 || irq !== 1'b1 || out_port !== 8'h77)
            $display("FAIL done_collision: status=%h irq=%b out_port=%h expected done=1 irq=1 77", rd, irq, out_port);
        else n_pass++;
        bus_write(A_STATUS, 32'h100);
    endtask

    initial begin
        test_reset();
        test_oneshot_nofade();
        test_fade();
        test_loop();
        test_random();
        test_reset_mid_fade();
        test_done_collision();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/led_color_sequencer.md
Name: led_color_sequencer

Overview:
Avalon-MM slave that steps one 8-bit LED colour channel through a programmable table of levels, autonomously and without CPU involvement. It supports a per-entry dwell time, an optional linear fade between entries, and one-shot or looping playback. It drives `out_port` in place of a plain colour PIO register, and it raises an interrupt when a one-shot sequence completes.

Parameters:
- DEPTH, 8: number of table entries. Legal range is 2..8, fixed by the address map.
- DWELL_W, 24: width of the dwell counter and the DWELL register.
- FDIV_W, 16: width of the fade-divider counter and the FADE_DIV register.

Ports:
- clk, input, 1: single system clock.
- reset_n, input, 1: asynchronous active-low reset.
- address, input, 4: register select.
- chipselect, input, 1: slave select.
- write_n, input, 1: active-low write strobe. A write occurs when chipselect=1 and write_n=0.
- writedata, input, 32: write data.
- readdata, output, 32: combinational read of the addressed register. Unused bits read 0.
- out_port, output, 8: current LED level, registered.
- irq, output, 1: level interrupt, equal to the STATUS.done bit.

Behaviour:
- Register map:
  - 0 CTRL: [0] run, [1] loop, [2] fade_en.
  - 1 DWELL: [DWELL_W-1:0] hold cycles per entry.
  - 2 FADE_DIV: [FDIV_W-1:0] cycles per ±1 fade step.
  - 3 LEN: [3:0] number of active entries.
  - 4 STATUS (read-only except W1C): [0] busy, [6:4] idx, [8] done. Writing 1 to bit 8 clears done.
  - 5 MANUAL: [7:0] level driven while idle.
  - 6–7: reserved. Writes are ignored; reads return 0.
  - 8..8+DEPTH-1 TABLE[i]: [7:0]. Addresses at or beyond 8+DEPTH read 0, and writes to them are ignored.
- Reset values: all registers 0, state IDLE, level 0. Therefore out_port=0, irq=0, and readdata reads 0 at every address.
- Effective values:
  - LEN of 0 is treated as 1; LEN above DEPTH is treated as DEPTH.
  - DWELL of 0 is treated as 1.
  - FADE_DIV of 0 is treated as 1.
- FSM states: IDLE, FADE, HOLD.
- IDLE:
  - level <= MANUAL every cycle, so out_port follows MANUAL with 1-cycle latency.
  - busy=0.
  - Start condition: a CTRL write with run=1 while in IDLE. On start, idx <= 0 and done is not changed.
  - If fade_en=1: enter FADE and load the divider.
  - If fade_en=0: level <= TABLE[0], enter HOLD, and load the dwell counter.
- FADE:
  - The divider counts FADE_DIV cycles. On expiry, level steps ±1 toward TABLE[idx].
  - When level equals TABLE[idx] (checked every cycle, including on entry), enter HOLD with the dwell counter loaded.
  - Level never overshoots the target and never wraps.
- HOLD:
  - The dwell counter counts DWELL cycles.
  - If idx < LEN-1 on expiry: idx++, then go to FADE (fade_en=1) or jump the level and stay in HOLD with the counter reloaded (fade_en=0).
  - If idx == LEN-1 and loop=1: idx <= 0, then proceed as above.
  - If idx == LEN-1 and loop=0: go to IDLE, clear CTRL.run, and set done (irq=1).
  - The level seen on the cycle after the last dwell expires is MANUAL.
- Abort: a CTRL write with run=0 in FADE or HOLD sends the FSM to IDLE on the next edge. done is not set, and out_port shows MANUAL one cycle later.
- CTRL write with run=1 while already busy: only loop and fade_en are updated; there is no restart.
- Live updates: TABLE, DWELL, FADE_DIV and LEN writes take effect immediately.
  - New DWELL and FADE_DIV values are used at the next counter load.
  - A TABLE write to the current idx retargets an in-progress fade.
  - If LEN shrinks to at or below idx, the next HOLD expiry is treated as the last-entry case.
- Simultaneous sequence end and W1C of done: the set wins, so done ends at 1.
- reset_n asserted mid-operation: immediate return to reset values.

Decomposition:
- Shared package:
  - register address constants (ADDR_CTRL..ADDR_TABLE_BASE);
  - CTRL/STATUS bit indices;
  - FSM state enum {IDLE, FADE, HOLD}.
- One natural sub-module: led_seq_timer, a loadable down-counter with an expiry pulse. It is instantiated twice: for dwell (DWELL_W) and for the fade divider (FDIV_W).
- The register file and read mux stay in the top level.

Test Plan:
1. Reset, then read all addresses → readdata=0, out_port=0, irq=0. Write MANUAL=0x5A → out_port=0x5A one cycle later.
2. No-fade one-shot: TABLE={0x10,0x20,0x30}, LEN=3, DWELL=4, CTRL=0x1.
   - out_port is 0x10, 0x20, 0x30, each for 4 cycles.
   - Then out_port returns to MANUAL, done=1, irq=1, CTRL.run=0.
   - W1C of STATUS bit 8 → irq=0.
3. Fade: MANUAL=0x00, TABLE[0]=0x04, LEN=1, FADE_DIV=3, DWELL=2, CTRL=0x5.
   - out_port rises 1,2,3,4, one step every 3 cycles.
   - Then a 2-cycle hold, then the sequence ends. Repeat with a downward target and check there is no overshoot.
4. Loop: LEN=2, loop=1. idx cycles 0,1,0,1 for at least 3 periods with done never set. Write CTRL=0 mid-HOLD → IDLE next cycle, done=0.
5. Edge values: DWELL=0 and FADE_DIV=0 behave as 1. LEN=0 plays only entry 0. LEN=15 is clamped to DEPTH. Address 8+DEPTH reads 0.
6. Async reset_n pulse mid-FADE → out_port=0, state IDLE, and all registers 0 immediately. Sequence end coincident with a done W1C → done=1.
